// File: rtl/key_conditioner.sv
// key_conditioner
//
// Turns the raw DE1-SoC push-buttons into clean signals on the clk domain.
// These buttons are active-low, bounce, and are asynchronous to clk. Each
// key channel is independent and does the following:
//   1. A 2-flop synchronizer on key_n.
//   2. A debounce counter. A new level is accepted only after
//      DEBOUNCE_CYCLES consecutive samples disagree with the current level.
//   3. One-cycle press and release pulses. Each pulse is registered on the
//      same edge as the change on pressed.
//   4. An optional hold-to-repeat FSM. It runs IDLE -> DELAY -> RPT.
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   reset         asynchronous, active-low; 0 clears all state immediately
//   key_n         raw buttons, 0 = pressed
//   pressed       debounced level, 1 = held
//   press_pulse   one cycle high on each accepted press
//   release_pulse one cycle high on each accepted release
//   repeat_pulse  one cycle high per repeat event while held
//   rpt_state     repeat FSM state, 2 bits per key
//                 (0 = IDLE, 1 = DELAY, 2 = RPT); key i uses bits [2i+1:2i]
//
// Valid/ready: this block has no handshake. Every output is a registered
// level or a single-cycle strobe, valid on every cycle, and cannot stall.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int RPT_W           = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_KEYS-1:0]     key_n,
  output logic [N_KEYS-1:0]     pressed,
  output logic [N_KEYS-1:0]     press_pulse,
  output logic [N_KEYS-1:0]     release_pulse,
  output logic [N_KEYS-1:0]     repeat_pulse,
  output logic [2*N_KEYS-1:0]   rpt_state
);

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_t;

  // Terminal counts. Each counter clears on its terminal value, so no
  // counter can wrap while the parameters are legal.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  // The synchronizer keeps key_n polarity. Both flops reset to 1, which
  // means "released", so a key already held when reset ends is seen as a
  // fresh press.
  logic [N_KEYS-1:0] meta_n;
  logic [N_KEYS-1:0] sync_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_n <= '1;
      sync_n <= '1;
    end else begin
      meta_n <= key_n;
      sync_n <= meta_n;
    end
  end

  genvar i;
  generate
    for (i = 0; i < N_KEYS; i++) begin : g_ch
      logic             level;
      logic             lvl_q;
      logic             press_q;
      logic             rel_q;
      logic [CNT_W-1:0] cnt;
      logic             accept;

      assign level  = ~sync_n[i];
      // accept is high on the edge where the debounced level toggles.
      assign accept = (level != lvl_q) && (cnt == DB_LAST);

      // Debounce. Any sample that agrees with the current level restarts
      // the count, so a single bounce throws away all progress.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lvl_q   <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          cnt     <= '0;
        end else begin
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          if (level == lvl_q) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt     <= '0;
            lvl_q   <= level;
            press_q <= level;
            rel_q   <= ~level;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign pressed[i]       = lvl_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = rel_q;

      if (REPEAT_EN != 0) begin : g_rpt
        rpt_state_t       st;
        logic [RPT_W-1:0] rcnt;
        logic             rep_q;

        // The FSM is in DELAY or RPT only while the key is held. In those
        // states an accept can therefore only be a release, and the release
        // takes priority over a repeat due on the same edge.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            st    <= RPT_IDLE;
            rcnt  <= '0;
            rep_q <= 1'b0;
          end else begin
            rep_q <= 1'b0;
            case (st)
              RPT_IDLE: begin
                if (accept && level) begin
                  st   <= RPT_DELAY;
                  rcnt <= '0;
                end
              end
              RPT_DELAY: begin
                if (accept) begin
                  st   <= RPT_IDLE;
                  rcnt <= '0;
                end else if (rcnt == DLY_LAST) begin
                  rep_q <= 1'b1;
                  rcnt  <= '0;
                  st    <= RPT_RUN;
                end else begin
                  rcnt <= rcnt + 1'b1;
                end
              end
              RPT_RUN: begin
                if (accept) begin
                  st   <= RPT_IDLE;
                  rcnt <= '0;
                end else if (rcnt == RATE_LAST) begin
                  rep_q <= 1'b1;
                  rcnt  <= '0;
                end else begin
                  rcnt <= rcnt + 1'b1;
                end
              end
              default: begin
                st   <= RPT_IDLE;
                rcnt <= '0;
              end
            endcase
          end
        end

        assign repeat_pulse[i]     = rep_q;
        assign rpt_state[2*i +: 2] = st;
      end else begin : g_no_rpt
        assign repeat_pulse[i]     = 1'b0;
        assign rpt_state[2*i +: 2] = RPT_IDLE;
      end
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner, built with small parameters:
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
//
// The reference model is written from the block's rules, not its structure:
//   - a key's level is accepted once the last DEBOUNCE_CYCLES synchronized
//     samples all disagree with the current level;
//   - repeats fall at elapsed = REPEAT_DELAY + k*REPEAT_RATE after the press;
//   - the repeat state follows from the held flag and the elapsed time.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [NK-1:0]   key_n;
  logic [NK-1:0]   pressed, press_pulse, release_pulse, repeat_pulse;
  logic [2*NK-1:0] rpt_state;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(8), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .rpt_state(rpt_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [NK-1:0]   m_s1, m_s2;
  logic [NK-1:0]   m_pressed, m_pp, m_rp, m_rep;
  logic [2*NK-1:0] m_state;
  logic [DB-1:0]   win [NK];
  int              nfill [NK];
  int              t_press [NK];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1;
    m_pressed = '0; m_pp = '0; m_rp = '0; m_rep = '0; m_state = '0;
    for (int i = 0; i < NK; i++) begin
      win[i] = '0; nfill[i] = 0; t_press[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NK; i++) begin
      logic lvl;
      int   el;
      lvl = ~m_s2[i];
      win[i] = {win[i][DB-2:0], lvl};
      if (nfill[i] < DB) nfill[i]++;
      m_pp[i] = 1'b0; m_rp[i] = 1'b0; m_rep[i] = 1'b0;
      if (nfill[i] == DB && win[i] == {DB{~m_pressed[i]}}) begin
        m_pressed[i] = ~m_pressed[i];
        if (m_pressed[i]) begin
          m_pp[i] = 1'b1; t_press[i] = cyc;
        end else begin
          m_rp[i] = 1'b1;
        end
      end
      el = cyc - t_press[i];
      if (m_pressed[i] && el >= RD && (el - RD) % RR == 0) m_rep[i] = 1'b1;
      if (!m_pressed[i])  m_state[2*i +: 2] = 2'd0;
      else if (el < RD)   m_state[2*i +: 2] = 2'd1;
      else                m_state[2*i +: 2] = 2'd2;
    end
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("pressed",       {4'b0, pressed},       {4'b0, m_pressed});
    cmp("press_pulse",   {4'b0, press_pulse},   {4'b0, m_pp});
    cmp("release_pulse", {4'b0, release_pulse}, {4'b0, m_rp});
    cmp("repeat_pulse",  {4'b0, repeat_pulse},  {4'b0, m_rep});
    cmp("rpt_state",     rpt_state,             m_state);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model at the edge, then check 1 time unit later.
  // Inputs are changed by the caller after the task returns.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic sel_bit(input int which, input int ch);
    case (which)
      0:       return press_pulse[ch];
      1:       return release_pulse[ch];
      default: return repeat_pulse[ch];
    endcase
  endfunction

  // Returns the number of edges until the chosen pulse appears, or -1 if it
  // does not appear within max edges.
  task automatic wait_for(input int which, input int ch, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (sel_bit(which, ch) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic settle();
    key_n = '1;
    steps(14);
  endtask

  // Stops the run if something hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int seen;
    model_reset();
    key_n = 4'b0000;
    reset = 1'b1;
    #1 reset = 1'b0;

    // 1. Reset is held while all keys are down; then it is released.
    steps(4);
    reset = 1'b1;
    wait_for(0, 0, 12, n);
    cmp_int("reset_release_latency", n, 6);
    cmp("press_all", {4'b0, press_pulse}, 8'h0f);
    step();
    cmp("press_one_cycle", {4'b0, press_pulse}, 8'h00);
    settle();

    // 2. Clean press, then release, on key 0.
    key_n[0] = 1'b0;
    wait_for(0, 0, 12, n);
    cmp_int("k0_press_latency", n, 6);
    steps(20);
    key_n[0] = 1'b1;
    wait_for(1, 0, 12, n);
    cmp_int("k0_release_latency", n, 6);
    settle();

    // 3. Bounce rejection.
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    seen = 0;
    foreach (exp_q[j]) begin
      key_n[0] = exp_q[j][0];
      step();
      if (press_pulse[0]) seen++;
    end
    key_n[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (press_pulse[0]) seen++;
    end
    cmp_int("bounce_no_press", seen, 0);
    wait_for(0, 0, 12, n);
    cmp_int("bounce_then_steady", n + 2, 6);
    settle();

    // 4. Hold-to-repeat on key 1.
    key_n[1] = 1'b0;
    wait_for(0, 1, 12, n);
    cmp_int("k1_press_latency", n, 6);
    exp_q = {};
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(RD + RR * k));
    seen = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (repeat_pulse[1]) begin
        if (seen < exp_q.size()) cmp_int("k1_repeat_offset", k, int'(exp_q[seen]));
        seen++;
      end
    end
    cmp_int("k1_repeat_count", seen, 6);
    key_n[1] = 1'b1;
    wait_for(1, 1, 12, n);
    cmp_int("k1_release_latency", n, 6);
    cmp("k1_no_rpt_on_release", {7'b0, repeat_pulse[1]}, 8'h00);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (repeat_pulse[1]) seen++;
    end
    cmp_int("k1_no_rpt_after_release", seen, 0);
    cmp("k1_state_idle", {6'b0, rpt_state[3:2]}, 8'h00);

    // 5. Keys 2 and 3 pressed together; key 3 released early.
    key_n[2] = 1'b0;
    key_n[3] = 1'b0;
    wait_for(0, 2, 12, n);
    cmp_int("k2_press_latency", n, 6);
    cmp("k3_press_same_edge", {7'b0, press_pulse[3]}, 8'h01);
    seen = 0;
    n = -1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (release_pulse[3]) n = k;
      if (repeat_pulse[2]) begin
        if (seen < exp_q.size()) cmp_int("k2_repeat_offset", k, int'(exp_q[seen]));
        seen++;
      end
      if (k == 8) key_n[3] = 1'b1;
    end
    cmp_int("k3_release_offset", n, 14);
    cmp_int("k2_repeat_count", seen, 6);
    settle();

    // 6. Reset pulse while key 1 is in RPT.
    key_n[1] = 1'b0;
    wait_for(0, 1, 12, n);
    steps(14);
    cmp("k1_in_rpt", {6'b0, rpt_state[3:2]}, 8'h02);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    cmp("async_clear", {pressed, repeat_pulse}, 8'h00);
    step();
    reset = 1'b1;
    wait_for(0, 1, 12, n);
    cmp_int("k1_repress_latency", n, 6);
    wait_for(2, 1, 14, n);
    cmp_int("k1_first_repeat", n, RD);
    settle();

    // Random phase: keys flip at random, with rare reset pulses.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 9) == 0) key_n[i] = ~key_n[i];
      if (!reset)                            reset = 1'b1;
      else if ($urandom_range(0, 249) == 0)  reset = 1'b0;
      step();
    end
    reset = 1'b1;
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
